// File: rtl/chess_snd_pkg.sv
// Shared definitions for the chess sound effect sequencer.
// Holds the sound-code constants, the pitch enumeration, the sequencer
// state encoding, the half-period table and the melody ROM.
package chess_snd_pkg;

  localparam logic [2:0] SND_STOP     = 3'd0;
  localparam logic [2:0] SND_MOVE     = 3'd1;
  localparam logic [2:0] SND_SELECT   = 3'd2;
  localparam logic [2:0] SND_CAPTURE  = 3'd3;
  localparam logic [2:0] SND_CHECK    = 3'd4;
  localparam logic [2:0] SND_ILLEGAL  = 3'd5;
  localparam logic [2:0] SND_PROMO    = 3'd6;
  localparam logic [2:0] SND_GAMEOVER = 3'd7;

  // Half-period counts fit in 18 bits (largest is C4 = 191113).
  localparam int HP_W = 18;

  typedef enum logic [2:0] {P_REST, P_C4, P_C5, P_E5, P_G5, P_A5, P_C6} pitch_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TONE, S_GAP} snd_state_e;

  typedef struct packed {
    pitch_e     pitch;
    logic [1:0] units;
  } note_t;

  // REST never reaches pwm, so its count only has to be harmless.
  function automatic logic [HP_W-1:0] half_period(input pitch_e p);
    case (p)
      P_C4:    return 18'd191113;
      P_C5:    return 18'd95557;
      P_E5:    return 18'd75843;
      P_G5:    return 18'd63776;
      P_A5:    return 18'd56818;
      P_C6:    return 18'd47778;
      default: return '1;
    endcase
  endfunction

  // A melody ends after note 3 or at the first entry with units == 0.
  function automatic note_t melody_note(input logic [2:0] code, input logic [1:0] idx);
    note_t n;
    n = '{pitch: P_REST, units: 2'd0};
    case (code)
      SND_STOP:    ;
      SND_MOVE:    if (idx == 2'd0) n = '{P_C5, 2'd1};
      SND_SELECT:  if (idx == 2'd0) n = '{P_E5, 2'd1};
      SND_CAPTURE:
        case (idx)
          2'd0:    n = '{P_G5, 2'd1};
          2'd1:    n = '{P_C6, 2'd2};
          default: ;
        endcase
      SND_CHECK:
        case (idx)
          2'd0:    n = '{P_A5, 2'd1};
          2'd1:    n = '{P_REST, 2'd1};
          2'd2:    n = '{P_A5, 2'd1};
          default: ;
        endcase
      SND_ILLEGAL: if (idx == 2'd0) n = '{P_C4, 2'd3};
      SND_PROMO:
        case (idx)
          2'd0:    n = '{P_C5, 2'd1};
          2'd1:    n = '{P_E5, 2'd1};
          2'd2:    n = '{P_G5, 2'd1};
          default: n = '{P_C6, 2'd1};
        endcase
      SND_GAMEOVER:
        case (idx)
          2'd0:    n = '{P_C6, 2'd2};
          2'd1:    n = '{P_G5, 2'd2};
          2'd2:    n = '{P_E5, 2'd2};
          default: n = '{P_C5, 2'd2};
        endcase
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] melody_units(input logic [2:0] code, input logic [1:0] idx);
    note_t n;
    n = melody_note(code, idx);
    return n.units;
  endfunction

endpackage

// File: rtl/snd_tone_gen.sv
// Square-wave tone generator.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en       : advance the half-period counter this cycle
//   clr      : restart the waveform phase (counter 0, tone high)
//   hp       : half-period length in clk cycles
//   tone     : raw square wave, toggles each time the counter wraps at hp-1
module snd_tone_gen
  import chess_snd_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [HP_W-1:0] hp,
  output logic            tone
);

  logic [HP_W-1:0] cnt_q;

  // Clearing presets the tone high so every note starts on a rising phase.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
      tone  <= 1'b1;
    end else if (en) begin
      if (cnt_q == hp - HP_W'(1)) begin
        cnt_q <= '0;
        tone  <= ~tone;
      end else begin
        cnt_q <= cnt_q + HP_W'(1);
      end
    end
  end

endmodule

// File: rtl/sound_seq.sv
// Chess sound effect sequencer: plays short melodies from a ROM as a
// square wave on pwm.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   sound_code : requested effect, sampled with play_sound
//   play_sound : single-cycle request strobe
//   mute       : forces pwm low while sequencing continues
//   pwm        : registered square-wave audio output
//   busy       : a melody is playing
//   cur_code   : code of the playing melody, 0 when idle
module sound_seq
  import chess_snd_pkg::*;
#(
  parameter int UNIT_CYC = 5000000,
  parameter int GAP_CYC  = 500000
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sound_code,
  input  logic       play_sound,
  input  logic       mute,
  output logic       pwm,
  output logic       busy,
  output logic [2:0] cur_code
);

  snd_state_e      state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0]      code_d;
  pitch_e          pitch_q;
  logic [1:0]      units_q;
  logic [31:0]     cnt_q;
  logic [31:0]     tone_len;
  logic [31:0]     gap_len;
  note_t           rom_note;
  logic [1:0]      next_units;
  logic            accept, stop;
  pitch_e          play_pitch;
  logic [HP_W-1:0] play_hp;
  logic            tone, tone_en, tone_clr;
  logic            pwm_d;

  assign busy       = (state_q != S_IDLE);
  assign rom_note   = melody_note(cur_code, idx_q);
  assign next_units = melody_units(cur_code, idx_q + 2'd1);
  assign tone_len   = {30'd0, units_q} * 32'(UNIT_CYC);
  assign gap_len    = 32'(GAP_CYC);

  // Equal or higher codes preempt; a stop only matters while playing.
  assign accept = play_sound && (busy ? (sound_code >= cur_code) : (sound_code != SND_STOP));
  assign stop   = play_sound && busy && (sound_code == SND_STOP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = cur_code;
    if (accept) begin
      state_d = S_LOAD;
      idx_d   = 2'd0;
      code_d  = sound_code;
    end else if (stop) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
      code_d  = SND_STOP;
    end else begin
      case (state_q)
        S_LOAD: state_d = S_TONE;
        S_TONE: if (cnt_q == tone_len - 32'd1) state_d = S_GAP;
        S_GAP:
          if (cnt_q == gap_len - 32'd1) begin
            if (idx_q == 2'd3 || next_units == 2'd0) begin
              state_d = S_IDLE;
              idx_d   = 2'd0;
              code_d  = SND_STOP;
            end else begin
              state_d = S_LOAD;
              idx_d   = idx_q + 2'd1;
            end
          end
        default: ;
      endcase
    end
  end

  // The pitch registers are only loaded at the end of LOAD, so during LOAD
  // the tone generator and the first pwm value take the pitch from the ROM.
  assign play_pitch = (state_q == S_LOAD) ? rom_note.pitch : pitch_q;
  assign play_hp    = half_period(play_pitch);
  assign tone_en    = (state_q == S_LOAD) || (state_q == S_TONE);
  assign tone_clr   = (state_d != S_TONE);

  // The generator runs one cycle ahead of pwm: its value now becomes pwm
  // on the next edge, which keeps pwm registered without shifting the phase.
  assign pwm_d = (state_d == S_TONE) && (play_pitch != P_REST) && tone && !mute;

  snd_tone_gen u_tone (
    .clk  (clk),
    .rst  (rst),
    .en   (tone_en),
    .clr  (tone_clr),
    .hp   (play_hp),
    .tone (tone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      cur_code <= SND_STOP;
      pitch_q  <= P_REST;
      units_q  <= 2'd0;
      cnt_q    <= '0;
      pwm      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cur_code <= code_d;
      if (state_q == S_LOAD) begin
        pitch_q <= rom_note.pitch;
        units_q <= rom_note.units;
      end
      // One counter times both TONE and GAP; any state change restarts it.
      if ((state_d == state_q) && (state_q == S_TONE || state_q == S_GAP))
        cnt_q <= cnt_q + 32'd1;
      else
        cnt_q <= '0;
      pwm <= pwm_d;
    end
  end

endmodule
